// File: rtl/bbtron_pkg.sv
// Shared definitions for the bbtron fetch/sequencing front end: opcodes,
// fetch-state encoding and default widths.
package bbtron_pkg;

   localparam int unsigned DEF_ADDR_W  = 10;
   localparam int unsigned DEF_INSTR_W = 32;
   localparam int unsigned OPCODE_W    = 6;

   localparam logic [OPCODE_W-1:0] OP_BEQ = 6'b001001;
   localparam logic [OPCODE_W-1:0] OP_BNE = 6'b001010;
   localparam logic [OPCODE_W-1:0] OP_IN  = 6'b010101;
   localparam logic [OPCODE_W-1:0] OP_JMP = 6'b010111;
   localparam logic [OPCODE_W-1:0] OP_HLT = 6'b011000;
   localparam logic [OPCODE_W-1:0] OP_RST = 6'b011001;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_LATCH,
      ST_EXEC,
      ST_WAIT_IN,
      ST_HALT
   } fetch_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection for the EXEC state, resolving the decoder's sequencing
// controls in strict priority order.
module pc_next_logic
   import bbtron_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [ADDR_W-1:0] i_jmp_target,
   input  logic [15:0]       i_imm,
   input  logic              i_bne,
   input  logic              i_reset,
   input  logic              i_hlt,
   input  logic              i_in,
   input  logic              i_jump,
   input  logic              i_branch,
   input  logic              i_alu_zero,
   output logic [ADDR_W-1:0] o_next_pc,
   output logic              o_branch_taken
);

   localparam int unsigned EXT_W = (ADDR_W > 16) ? ADDR_W : 16;

   logic [ADDR_W-1:0]       w_pc_inc;
   logic signed [EXT_W-1:0] w_imm_ext;
   logic [ADDR_W-1:0]       w_target;
   logic                    w_cond;

   assign w_pc_inc  = i_pc + ADDR_W'(1);
   assign w_imm_ext = EXT_W'($signed(i_imm));
   // Sum is formed at the wider width then truncated, so the result wraps mod 2^ADDR_W.
   assign w_target  = ADDR_W'(EXT_W'(w_pc_inc) + w_imm_ext);
   assign w_cond    = i_alu_zero ^ i_bne;

   always_comb begin
      o_next_pc      = w_pc_inc;
      o_branch_taken = 1'b0;
      if (i_reset) begin
         o_next_pc = '0;
      end else if (i_hlt) begin
         o_next_pc = w_pc_inc;
      end else if (i_in) begin
         o_next_pc = i_pc;
      end else if (i_jump) begin
         o_next_pc = i_jmp_target;
      end else if (i_branch) begin
         o_branch_taken = w_cond;
         if (w_cond) o_next_pc = w_target;
      end
   end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer: FETCH/LATCH/EXEC loop over a synchronous ROM,
// with input-wait, halt and soft-reset handling and a per-instruction commit.
module instruction_fetch_sequencer
   import bbtron_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned INSTR_W = DEF_INSTR_W
) (
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  rom_addr,
   output logic               rom_en,
   input  logic [INSTR_W-1:0] rom_data,
   output logic [5:0]         opcode,
   output logic [INSTR_W-1:0] instr,
   input  logic               cu_Jump,
   input  logic               cu_Branch,
   input  logic               cu_hlt,
   input  logic               cu_reset,
   input  logic               cu_inSignal,
   input  logic               alu_zero,
   input  logic               in_valid,
   input  logic               resume,
   output logic               commit,
   output logic               soft_rst,
   output logic               halted,
   output logic [ADDR_W-1:0]  pc
);

   fetch_state_e       r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic [INSTR_W-1:0] r_ir;
   logic [ADDR_W-1:0]  w_next_pc;
   logic               w_branch_taken;
   logic               w_exec_retire;

   pc_next_logic #(.ADDR_W(ADDR_W)) u_pc_next (
      .i_pc           (r_pc),
      .i_jmp_target   (r_ir[ADDR_W-1:0]),
      .i_imm          (r_ir[15:0]),
      .i_bne          (r_ir[INSTR_W-5]),
      .i_reset        (cu_reset),
      .i_hlt          (cu_hlt),
      .i_in           (cu_inSignal),
      .i_jump         (cu_Jump),
      .i_branch       (cu_Branch),
      .i_alu_zero     (alu_zero),
      .o_next_pc      (w_next_pc),
      .o_branch_taken (w_branch_taken)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_FETCH;
         r_pc    <= '0;
         r_ir    <= '0;
      end else begin
         case (r_state)
            ST_FETCH: r_state <= ST_LATCH;
            ST_LATCH: begin
               r_ir    <= rom_data;
               r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               r_pc <= w_next_pc;
               if (cu_reset)         r_state <= ST_FETCH;
               else if (cu_hlt)      r_state <= ST_HALT;
               else if (cu_inSignal) r_state <= ST_WAIT_IN;
               else                  r_state <= ST_FETCH;
            end
            ST_WAIT_IN: begin
               if (in_valid) begin
                  r_pc    <= r_pc + ADDR_W'(1);
                  r_state <= ST_FETCH;
               end
            end
            ST_HALT: if (resume) r_state <= ST_FETCH;
            default: r_state <= ST_FETCH;
         endcase
      end
   end

   // Strobes decode the registered state; rom_en is also masked while rst is held.
   assign w_exec_retire = (r_state == ST_EXEC) && !cu_reset && !cu_hlt && !cu_inSignal;
   assign commit        = w_exec_retire || ((r_state == ST_WAIT_IN) && in_valid);
   assign soft_rst      = (r_state == ST_EXEC) && cu_reset;
   assign rom_en        = (r_state == ST_FETCH) && !rst;
   assign rom_addr      = r_pc;
   assign halted        = (r_state == ST_HALT);
   assign pc            = r_pc;
   assign opcode        = r_ir[INSTR_W-1 -: 6];
   assign instr         = r_ir;

   a_taken_branch_commits: assert property (@(posedge clk) disable iff (rst)
      ((r_state == ST_EXEC) && w_branch_taken) |-> commit);

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Self-checking bench: synchronous ROM model and decoder stub around the
// sequencer, compared against a program-level next-PC reference model.
module tb_instruction_fetch_sequencer;
   import bbtron_pkg::*;

   localparam int ROM_N = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  rom_addr;
   logic        rom_en;
   logic [31:0] rom_data = '0;
   logic [5:0]  opcode;
   logic [31:0] instr;
   logic        cu_Jump, cu_Branch, cu_hlt, cu_reset, cu_inSignal;
   logic        alu_zero = 1'b0;
   logic        in_valid = 1'b0;
   logic        resume = 1'b0;
   logic        commit, soft_rst, halted;
   logic [9:0]  pc;
   logic        force_jump = 1'b0;

   logic [31:0] rom [0:ROM_N-1];
   int          m_pc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

   // Decoder stand-in; force_jump drives a don't-care cu_Jump high to probe priority.
   assign cu_reset    = (opcode == OP_RST);
   assign cu_hlt      = (opcode == OP_HLT);
   assign cu_inSignal = (opcode == OP_IN);
   assign cu_Jump     = (opcode == OP_JMP) || force_jump;
   assign cu_Branch   = (opcode == OP_BEQ) || (opcode == OP_BNE);

   instruction_fetch_sequencer dut (
      .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
      .opcode(opcode), .instr(instr), .cu_Jump(cu_Jump), .cu_Branch(cu_Branch),
      .cu_hlt(cu_hlt), .cu_reset(cu_reset), .cu_inSignal(cu_inSignal), .alu_zero(alu_zero),
      .in_valid(in_valid), .resume(resume), .commit(commit), .soft_rst(soft_rst),
      .halted(halted), .pc(pc)
   );

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] rest);
      return {op, rest};
   endfunction

   // Program-level rule: where the next instruction comes from.
   function automatic int model_next(input int cur, input logic [31:0] w, input bit zero);
      logic [5:0] op;
      int t;
      op = w[31:26];
      t  = cur + 1;
      if (op == OP_RST) t = 0;
      else if (op == OP_JMP) t = int'(w[9:0]);
      else if ((op == OP_BEQ && zero) || (op == OP_BNE && !zero)) t = cur + 1 + int'($signed(w[15:0]));
      return ((t % ROM_N) + ROM_N) % ROM_N;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; resume = 1'b0; force_jump = 1'b0;
      #1;
      if (rom_en !== 1'b0) begin n_fail++; $display("FAIL rst_rom_en got=%b exp=0", rom_en); end n_checks++;
      if (commit !== 1'b0) begin n_fail++; $display("FAIL rst_commit got=%b exp=0", commit); end n_checks++;
      if (pc !== 10'd0 || rom_addr !== 10'd0) begin n_fail++; $display("FAIL rst_pc got=%0d/%0d exp=0", pc, rom_addr); end n_checks++;
      if (soft_rst !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL rst_flags got=%b%b exp=00", soft_rst, halted); end n_checks++;
      if (instr !== 32'd0) begin n_fail++; $display("FAIL rst_instr got=%h exp=0", instr); end n_checks++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      m_pc = 0;
      if (rom_en !== 1'b1) begin n_fail++; $display("FAIL first_fetch rom_en got=%b exp=1", rom_en); end n_checks++;
   endtask

   // Runs one instruction starting from its FETCH cycle; returns at the next FETCH.
   task automatic exec_one(input logic [31:0] word, input bit zero, input int hold);
      logic [5:0] op;
      int nxt;
      bit exp_commit;
      op = word[31:26];
      rom[m_pc] = word;
      if (rom_en !== 1'b1) begin n_fail++; $display("FAIL fetch_en got=%b exp=1", rom_en); end n_checks++;
      if (rom_addr !== 10'(m_pc) || pc !== 10'(m_pc)) begin n_fail++; $display("FAIL fetch_addr got=%0d pc=%0d exp=%0d", rom_addr, pc, m_pc); end n_checks++;
      alu_zero = zero;
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      resume   = 1'($urandom_range(0, 1));
      #1;
      if (commit !== 1'b0 || soft_rst !== 1'b0 || rom_en !== 1'b0) begin
         n_fail++; $display("FAIL latch_strobes got=c%b s%b e%b exp=000", commit, soft_rst, rom_en);
      end n_checks++;
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      resume   = (op == OP_HLT);
      #1;
      exp_commit = !(op == OP_RST || op == OP_HLT || op == OP_IN);
      if (instr !== word) begin n_fail++; $display("FAIL exec_instr got=%h exp=%h", instr, word); end n_checks++;
      if (commit !== exp_commit) begin n_fail++; $display("FAIL exec_commit op=%b got=%b exp=%b", op, commit, exp_commit); end n_checks++;
      if (soft_rst !== (op == OP_RST)) begin n_fail++; $display("FAIL exec_soft_rst got=%b exp=%b", soft_rst, op == OP_RST); end n_checks++;
      nxt = model_next(m_pc, word, zero);
      if (op == OP_IN) begin
         for (int i = 0; i < hold; i++) begin
            @(negedge clk); in_valid = 1'b0; resume = 1'($urandom_range(0, 1)); #1;
            if (commit !== 1'b0 || rom_en !== 1'b0) begin n_fail++; $display("FAIL wait_idle cyc=%0d got=c%b e%b exp=00", i, commit, rom_en); end n_checks++;
         end
         @(negedge clk); in_valid = 1'b1; resume = 1'b0; #1;
         if (commit !== 1'b1) begin n_fail++; $display("FAIL wait_commit got=%b exp=1", commit); end n_checks++;
         @(negedge clk); in_valid = 1'b0; #1;
      end else if (op == OP_HLT) begin
         for (int i = 0; i < hold; i++) begin
            @(negedge clk); resume = 1'b0; in_valid = 1'($urandom_range(0, 1)); #1;
            if (halted !== 1'b1 || rom_en !== 1'b0 || commit !== 1'b0) begin
               n_fail++; $display("FAIL halt_hold cyc=%0d got=h%b e%b c%b exp=100", i, halted, rom_en, commit);
            end n_checks++;
         end
         @(negedge clk); resume = 1'b1; in_valid = 1'b0; #1;
         if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_resume_cycle got=%b exp=1", halted); end n_checks++;
         @(negedge clk); resume = 1'b0; #1;
         if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_release got=%b exp=0", halted); end n_checks++;
      end else begin
         @(negedge clk); in_valid = 1'b0; resume = 1'b0; #1;
      end
      in_valid = 1'b0;
      resume   = 1'b0;
      m_pc     = nxt;
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_sequential();
      bit exp_c;
      do_reset();
      rom[0] = mk(6'b000000, 26'h0123);
      rom[1] = mk(6'b000000, 26'h0456);
      rom[2] = mk(6'b000000, 26'h0789);
      for (int c = 1; c <= 6; c++) begin
         exp_c = (c == 3 || c == 6);
         if (commit !== exp_c) begin n_fail++; $display("FAIL seq_commit cyc=%0d got=%b exp=%b", c, commit, exp_c); end n_checks++;
         if (c == 4 && pc !== 10'd1) begin n_fail++; $display("FAIL seq_pc1 got=%0d exp=1", pc); end
         if (c == 4) n_checks++;
         @(negedge clk); #1;
      end
      if (pc !== 10'd2 || rom_en !== 1'b1) begin n_fail++; $display("FAIL seq_pc2 got=%0d en=%b exp=2/1", pc, rom_en); end n_checks++;
      m_pc = 2;
   endtask

   task automatic test_branch();
      do_reset();
      exec_one(mk(OP_JMP, 26'd5), 1'b0, 0);
      exec_one(mk(OP_BEQ, {10'd0, 16'hFFFD}), 1'b1, 0);
      if (rom_addr !== 10'd3) begin n_fail++; $display("FAIL beq_target got=%0d exp=3", rom_addr); end n_checks++;
      do_reset();
      exec_one(mk(OP_JMP, 26'd5), 1'b0, 0);
      exec_one(mk(OP_BNE, {10'd0, 16'hFFFD}), 1'b1, 0);
      if (rom_addr !== 10'd6) begin n_fail++; $display("FAIL bne_fallthru got=%0d exp=6", rom_addr); end n_checks++;
   endtask

   task automatic test_wrap();
      do_reset();
      exec_one(mk(OP_JMP, 26'd1023), 1'b0, 0);
      exec_one(mk(OP_JMP, 26'd4), 1'b0, 0);
      if (pc !== 10'd4) begin n_fail++; $display("FAIL jmp_from_top got=%0d exp=4", pc); end n_checks++;
      do_reset();
      exec_one(mk(OP_JMP, 26'd1023), 1'b0, 0);
      exec_one(mk(6'b000000, 26'h3FFFFFF), 1'b0, 0);
      if (pc !== 10'd0) begin n_fail++; $display("FAIL pc_wrap got=%0d exp=0", pc); end n_checks++;
   endtask

   task automatic test_in_wait();
      do_reset();
      exec_one(mk(OP_JMP, 26'd2), 1'b0, 0);
      exec_one(mk(OP_IN, 26'd0), 1'b0, 7);
      if (pc !== 10'd3) begin n_fail++; $display("FAIL in_next_pc got=%0d exp=3", pc); end n_checks++;
   endtask

   task automatic test_halt();
      do_reset();
      exec_one(mk(OP_JMP, 26'd8), 1'b0, 0);
      exec_one(mk(OP_HLT, 26'd0), 1'b0, 20);
      if (rom_addr !== 10'd9 || rom_en !== 1'b1) begin n_fail++; $display("FAIL halt_refetch got=%0d en=%b exp=9/1", rom_addr, rom_en); end n_checks++;
   endtask

   task automatic test_soft_reset();
      do_reset();
      exec_one(mk(OP_JMP, 26'd12), 1'b0, 0);
      force_jump = 1'b1;
      exec_one(mk(OP_RST, 26'd5), 1'b1, 0);
      force_jump = 1'b0;
      if (rom_addr !== 10'd0 || soft_rst !== 1'b0) begin n_fail++; $display("FAIL soft_rst_refetch got=%0d s=%b exp=0/0", rom_addr, soft_rst); end n_checks++;
      exec_one(mk(6'b000000, 26'd0), 1'b0, 0);
   endtask

   task automatic test_abort();
      do_reset();
      exec_one(mk(OP_JMP, 26'd7), 1'b0, 0);
      rom[7] = mk(6'b000000, 26'h155);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      if (rom_en !== 1'b0 || commit !== 1'b0 || soft_rst !== 1'b0 || halted !== 1'b0) begin
         n_fail++; $display("FAIL abort_strobes got=e%b c%b s%b h%b exp=0000", rom_en, commit, soft_rst, halted);
      end n_checks++;
      if (pc !== 10'd0 || rom_addr !== 10'd0 || instr !== 32'd0) begin
         n_fail++; $display("FAIL abort_regs got=pc%0d a%0d i%h exp=0", pc, rom_addr, instr);
      end n_checks++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         if (commit !== 1'b0) begin n_fail++; $display("FAIL abort_commit cyc=%0d got=%b exp=0", i, commit); end n_checks++;
      end
      rst = 1'b0;
      #1;
      m_pc = 0;
      exec_one(mk(6'b000000, 26'd0), 1'b0, 0);
   endtask

   task automatic test_random();
      logic [5:0] op;
      do_reset();
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 9))
            3: op = OP_BEQ;
            4: op = OP_BNE;
            5: op = OP_JMP;
            6: op = OP_IN;
            7: op = OP_HLT;
            8: op = OP_RST;
            default: op = 6'b000000;
         endcase
         force_jump = (op == OP_RST) && ($urandom_range(0, 1) == 1);
         exec_one(mk(op, 26'($urandom)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
         force_jump = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_wrap();
      test_in_wait();
      test_halt();
      test_soft_reset();
      test_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1);
   end

endmodule

// File: doc/instruction_fetch_sequencer.md
# instruction_fetch_sequencer

Producer side of the opcode interface: fetches instruction words from a synchronous instruction ROM, holds them in an instruction register, and drives `opcode` into `controlUnity`. It consumes the decoder's sequencing outputs (`cu_Jump`, `cu_Branch`, `cu_hlt`, `cu_reset`, `cu_inSignal`) plus the ALU zero flag to compute the next PC. It also handles the halt, soft-reset and input-wait states. One `commit` strobe per instruction qualifies all datapath writes.

## Interface
- `ADDR_W`, default 10: PC and ROM address width.
- `INSTR_W`, default 32: instruction width; opcode is `[INSTR_W-1:INSTR_W-6]`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rom_addr`  out  ADDR_W  ROM address.
- `rom_en`  out  1  ROM read enable.
- `rom_data`  in  INSTR_W  ROM output; valid the cycle after `rom_en`.
- `opcode`  out  6  `ir[INSTR_W-1:INSTR_W-6]`, to `controlUnity`.
- `instr`  out  INSTR_W  full instruction register, to the datapath.
- `cu_Jump`, `cu_Branch`, `cu_hlt`, `cu_reset`, `cu_inSignal`  in  1 each  decoder outputs.
- `alu_zero`  in  1  ALU result == 0.
- `in_valid`  in  1  one-cycle pulse: external input word is ready.
- `resume`  in  1  one-cycle pulse: leave HALT.
- `commit`  out  1  instruction completes this cycle; gates register-file and memory writes.
- `soft_rst`  out  1  one-cycle pulse on a Reset opcode.
- `halted`  out  1  high in HALT.
- `pc`  out  ADDR_W  current PC.

## Operation
- States: FETCH, LATCH, EXEC, WAIT_IN, HALT.
- **FETCH:** `rom_addr`=`pc`, `rom_en`=1 → LATCH.
- **LATCH:** `ir` <= `rom_data` → EXEC.
- **EXEC:** the decoder outputs are valid. Resolve in priority order; lower-priority inputs are ignored, including X values:
  1. `cu_reset`: `pc`<=0, `soft_rst`=1, `commit`=0 → FETCH.
  2. `cu_hlt`: `pc`<=`pc`+1, `commit`=0 → HALT.
  3. `cu_inSignal`: `commit`=0 → WAIT_IN.
  4. `cu_Jump`: `pc`<=`ir[ADDR_W-1:0]`, `commit`=1 → FETCH.
  5. `cu_Branch`: taken = `alu_zero` XOR `opcode[1]` (BEQ 001001 is taken on zero; BNE 001010 is taken on nonzero). If taken, `pc`<=`pc`+1+sext(`ir[15:0]`), truncated to ADDR_W; else `pc`+1. `commit`=1 → FETCH.
  6. Otherwise: `pc`<=`pc`+1, `commit`=1 → FETCH.
- **WAIT_IN:** hold until `in_valid`. That cycle: `commit`=1, `pc`<=`pc`+1 → FETCH.
- **HALT:** `halted`=1, nothing fetched. `resume` → FETCH.
- **Arithmetic:** all PC arithmetic is modulo 2^ADDR_W; `pc`+1 at all-ones wraps to 0.
- `opcode` and `instr` are driven from `ir` in all states. Consumers qualify them only by `commit`.

## Timing
- **Reset values:** `pc`=0, `ir`=0, state=FETCH, `rom_en`=0 during reset, `commit`=0, `soft_rst`=0, `halted`=0, `rom_addr`=0.
- **First fetch:** `rom_en`=1 in the first cycle after `rst` deasserts.
- **Throughput:** 3 cycles per normal instruction (FETCH, LATCH, EXEC); `commit` is in EXEC. An IN instruction takes 3 cycles plus the wait.
- `commit` and `soft_rst` are combinational from state/inputs, registered-state based, and never high together.
- `in_valid` is ignored outside WAIT_IN.
- `resume` is ignored outside HALT. `resume` arriving in the same cycle EXEC enters HALT is lost.
- `rst` mid-instruction aborts immediately; no `commit` is issued for the aborted instruction.

## Structure
- Shared package `bbtron_pkg`:
  - opcode constants OP_BEQ=6'b001001, OP_BNE=6'b001010, OP_IN=6'b010101, OP_JMP=6'b010111, OP_HLT=6'b011000, OP_RST=6'b011001;
  - fetch-state enum;
  - default ADDR_W/INSTR_W.
- Sub-module `pc_next_logic`: combinational. Inputs: `pc`, `ir`, the sequencing controls, `alu_zero`. Outputs: next PC and branch-taken.

## Test plan
- Reset, ROM[0]=ADD, ROM[1]=ADD: `commit` in cycles 3 and 6 after reset release; `pc` 0→1→2.
- BEQ at pc=5, imm=-3, `alu_zero`=1: next fetch at 3. Same BNE with `alu_zero`=1: next fetch at 6.
- Jump at pc=1023, target=4: `pc`=4. ADD at pc=1023: `pc` wraps to 0.
- IN at pc=2, `in_valid` after 7 idle cycles: `commit` exactly once, in the `in_valid` cycle; `pc`=3.
- HLT at pc=8: `halted`=1, `rom_en`=0 for 20 cycles. `resume`: fetch at 9, `halted`=0.
- Reset opcode at pc=12 with `cu_Jump`=X: `soft_rst` pulses once, no `commit`, next fetch at 0. Also: async `rst` asserted during LATCH gives all outputs at reset values with no `commit`.
